game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//   Top-level game-flow controller for Frogger. Replaces the two-state IDLE/RUNNING FSM in the top level.
//   Adds lives, a timed death sequence, a level-up pause, a level counter and a game-over state.
//   Drives the enable/freeze/reset controls consumed by Frog_Movement, Obstacles_Movement and Sprite_Display.
//   Timing is frame-based, using a one-cycle per-frame tick from the VGA sync logic.
// PARAMETERS
//   c_LIVES_INI       3    lives loaded at game start (1..3)
//   c_DEATH_FRAMES    60   frames spent in DYING before respawn/game over (1..255)
//   c_LEVELUP_FRAMES  30   frames spent in LEVEL_PAUSE (1..255)
//   c_MAX_LEVEL       15   level counter saturation value (<=15)
// PORTS
//   i_Clk            in   1  system clock (25 MHz)
//   i_Rst_N          in   1  reset, asynchronous, active-low
//   i_Start          in   1  start request: all four debounced switches pressed
//   i_Frame_Tick     in   1  one-cycle pulse at start of each VGA frame
//   i_Has_Collided   in   1  frog/car overlap (level, may stay high several cycles)
//   i_Level_Up       in   1  one-cycle pulse: frog reached the far bank
//   o_Game_Active    out  1  1 only in RUNNING; gates frog movement
//   o_Obstacle_Freeze out 1  1 in IDLE, DYING, LEVEL_PAUSE, GAME_OVER
//   o_Frog_Reset     out  1  one-cycle pulse: return frog to base position
//   o_Frog_Blank     out  1  frog sprite hidden (blink during DYING)
//   o_Lives          out  2  remaining lives
//   o_Level          out  4  current level, 0-based
//   o_State          out  3  IDLE=0 RUNNING=1 DYING=2 LEVEL_PAUSE=3 GAME_OVER=4
// BEHAVIOUR
// - Reset (async assert, sync use): state=IDLE, frame counter=0, o_Lives=c_LIVES_INI, o_Level=0.
//   o_Frog_Reset=0, o_Frog_Blank=0, o_Game_Active=0, o_Obstacle_Freeze=1. Reset mid-sequence aborts it with no pulse.
// - All outputs are registered. A state change is visible on the cycle after the triggering input.
// - IDLE: on i_Start=1, go to RUNNING.
//   Same edge: o_Lives<=c_LIVES_INI, o_Level<=0, o_Frog_Reset pulses for 1 cycle.
// - RUNNING: i_Has_Collided=1 -> DYING. Same edge: o_Lives<=o_Lives-1 (never below 0), frame counter<=0.
//   Else i_Level_Up=1 -> LEVEL_PAUSE. Same edge: o_Level<=min(o_Level+1, c_MAX_LEVEL), frame counter<=0.
//   Collision and level-up in the same cycle: collision wins; level is not incremented.
// - DYING: frame counter increments on each i_Frame_Tick. o_Frog_Blank = frame counter bit 3 (8-frame blink).
//   Inputs are ignored while in DYING.
//   When the counter reaches c_DEATH_FRAMES-1 and a tick arrives:
//     o_Lives==0 -> GAME_OVER with o_Frog_Blank=1.
//     Otherwise -> RUNNING with an o_Frog_Reset pulse and o_Frog_Blank=0.
// - LEVEL_PAUSE: the counter runs the same way. On the c_LEVELUP_FRAMES-th tick -> RUNNING with o_Frog_Reset pulse.
//   Collisions are ignored during the pause.
// - GAME_OVER: o_Frog_Blank=1. i_Start=0 -> IDLE. IDLE then needs a new press.
// - Frame counter is 8 bits, cleared on every state entry, and does not wrap within a state.
// - Illegal o_State encodings return to IDLE on the next clock.
// - The counter only advances on i_Frame_Tick; clocks without a tick hold it.
// CONFIGURATION
//   START_EDGE_EN defined: IDLE->RUNNING only on a rising edge of i_Start (registered previous value).
//     Holding all switches through reset or GAME_OVER->IDLE does not restart.
//   START_EDGE_EN undefined: IDLE->RUNNING on i_Start level (=1). The GAME_OVER release rule is unchanged.
// TESTING
//   1. Rst_N=0 then 1, i_Start=1 for 1 clk -> next clk o_State=1, o_Lives=3, o_Level=0, o_Frog_Reset=1 for exactly 1 clk.
//   2. RUNNING, i_Has_Collided held 5 clks -> o_State=2, o_Lives=2 (one decrement only).
//      After 60 ticks -> o_State=1, one Frog_Reset pulse; o_Frog_Blank toggles every 8 ticks meanwhile.
//   3. Three collisions, each followed by 60 ticks -> o_Lives=0, o_State=4, o_Frog_Blank=1.
//      Then i_Start=0 -> o_State=0.
//   4. i_Level_Up and i_Has_Collided high in the same clk -> o_State=2, o_Level unchanged, o_Lives decremented.
//   5. 16 level-ups, each followed by 30 ticks -> o_Level saturates at 15. Obstacle_Freeze=1 only during the pauses.
//   6. Assert i_Rst_N=0 mid-DYING (tick 20) -> outputs take reset values immediately, without waiting for a clock edge.
//      With START_EDGE_EN and i_Start held high through reset -> stays IDLE until i_Start goes 0 then 1.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: Frogger game-flow FSM (lives, timed death blink, level-up pause, game over).
// Define START_EDGE_EN to start only on a rising edge of i_Start instead of its level.
module game_sequencer #(
  parameter int c_LIVES_INI      = 3,
  parameter int c_DEATH_FRAMES   = 60,
  parameter int c_LEVELUP_FRAMES = 30,
  parameter int c_MAX_LEVEL      = 15
)(
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Has_Collided,
  input  logic       i_Level_Up,
  output logic       o_Game_Active,
  output logic       o_Obstacle_Freeze,
  output logic       o_Frog_Reset,
  output logic       o_Frog_Blank,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic [2:0] o_State
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RUNNING     = 3'd1,
    DYING       = 3'd2,
    LEVEL_PAUSE = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;
  localparam logic [1:0] lives_ini = 2'(c_LIVES_INI);
  localparam logic [3:0] max_lvl   = 4'(c_MAX_LEVEL);
  localparam logic [7:0] death_end = 8'(c_DEATH_FRAMES - 1);
  localparam logic [7:0] pause_end = 8'(c_LEVELUP_FRAMES - 1);
  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx, cnt_tick;
  logic [1:0] lives_nx;
  logic [3:0] level_nx;
  logic       frog_reset_nx, start_go;
`ifdef START_EDGE_EN
  logic start_prev;
  // Reset to 1 so switches held through reset never look like a fresh press
  always_ff @(posedge i_Clk or negedge i_Rst_N)
    if (!i_Rst_N) start_prev <= 1'b1;
    else start_prev <= i_Start;
  assign start_go = i_Start & ~start_prev;
`else
  assign start_go = i_Start;
`endif
  always_comb begin
    state_nx      = state;
    lives_nx      = o_Lives;
    level_nx      = o_Level;
    frog_reset_nx = 1'b0;
    cnt_tick      = (i_Frame_Tick && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    cnt_nx        = cnt;
    case (state)
      IDLE: if (start_go) begin
        state_nx      = RUNNING;
        lives_nx      = lives_ini;
        level_nx      = 4'd0;
        frog_reset_nx = 1'b1;
      end
      RUNNING: if (i_Has_Collided) begin
        state_nx = DYING;
        lives_nx = (o_Lives == 2'd0) ? 2'd0 : o_Lives - 2'd1;
      end else if (i_Level_Up) begin
        state_nx = LEVEL_PAUSE;
        level_nx = (o_Level >= max_lvl) ? max_lvl : o_Level + 4'd1;
      end
      DYING: if (i_Frame_Tick && cnt == death_end) begin
        state_nx      = (o_Lives == 2'd0) ? GAME_OVER : RUNNING;
        frog_reset_nx = o_Lives != 2'd0;
      end else cnt_nx = cnt_tick;
      LEVEL_PAUSE: if (i_Frame_Tick && cnt == pause_end) begin
        state_nx      = RUNNING;
        frog_reset_nx = 1'b1;
      end else cnt_nx = cnt_tick;
      GAME_OVER: state_nx = i_Start ? GAME_OVER : IDLE;
      default: state_nx = IDLE;
    endcase
    // Every state entry restarts the frame count
    if (state_nx != state) cnt_nx = 8'd0;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_N)
    if (!i_Rst_N) begin
      state             <= IDLE;
      cnt               <= 8'd0;
      o_Lives           <= lives_ini;
      o_Level           <= 4'd0;
      o_Frog_Reset      <= 1'b0;
      o_Frog_Blank      <= 1'b0;
      o_Game_Active     <= 1'b0;
      o_Obstacle_Freeze <= 1'b1;
    end else begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      o_Lives           <= lives_nx;
      o_Level           <= level_nx;
      o_Frog_Reset      <= frog_reset_nx;
      o_Frog_Blank      <= (state_nx == GAME_OVER) | ((state_nx == DYING) & cnt_nx[3]);
      o_Game_Active     <= state_nx == RUNNING;
      o_Obstacle_Freeze <= state_nx != RUNNING;
    end
  assign o_State = state;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard bench for game_sequencer; expected output snapshots are queued per driven cycle.
module tb_game_sequencer;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_DIE = 3'd2, S_PAUSE = 3'd3, S_OVER = 3'd4;
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lv;
    logic [3:0] lvl;
    logic       act, frz, fr, blk;
  } snap_t;
  logic       i_Clk = 1'b0, i_Rst_N = 1'b0;
  logic       i_Start = 1'b0, i_Frame_Tick = 1'b0, i_Has_Collided = 1'b0, i_Level_Up = 1'b0;
  logic       o_Game_Active, o_Obstacle_Freeze, o_Frog_Reset, o_Frog_Blank;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic [2:0] o_State;
  snap_t      exp_q[$];
  string      tag_q[$];
  int         n_chk = 0, n_pass = 0;
  logic [1:0] lives;
  logic [3:0] level;
  game_sequencer dut (
    .i_Clk(i_Clk), .i_Rst_N(i_Rst_N), .i_Start(i_Start), .i_Frame_Tick(i_Frame_Tick),
    .i_Has_Collided(i_Has_Collided), .i_Level_Up(i_Level_Up),
    .o_Game_Active(o_Game_Active), .o_Obstacle_Freeze(o_Obstacle_Freeze),
    .o_Frog_Reset(o_Frog_Reset), .o_Frog_Blank(o_Frog_Blank),
    .o_Lives(o_Lives), .o_Level(o_Level), .o_State(o_State)
  );
  always #5 i_Clk = ~i_Clk;
  function automatic snap_t mk(logic [2:0] st, logic [1:0] lv, logic [3:0] lvl, logic fr, logic blk);
    return {st, lv, lvl, st == S_RUN, st != S_RUN, fr, blk};
  endfunction
  task automatic check(input string tag, input snap_t got, input snap_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got st=%0d lives=%0d lvl=%0d act=%b frz=%b fr=%b blk=%b exp st=%0d lives=%0d lvl=%0d act=%b frz=%b fr=%b blk=%b",
      tag, got.st, got.lv, got.lvl, got.act, got.frz, got.fr, got.blk,
      exp.st, exp.lv, exp.lvl, exp.act, exp.frz, exp.fr, exp.blk);
  endtask
  task automatic pop_check;
    check(tag_q.pop_front(),
      {o_State, o_Lives, o_Level, o_Game_Active, o_Obstacle_Freeze, o_Frog_Reset, o_Frog_Blank},
      exp_q.pop_front());
  endtask
  task automatic step(input logic s, t, c, u, input string tag, input snap_t e);
    i_Start = s; i_Frame_Tick = t; i_Has_Collided = c; i_Level_Up = u;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge i_Clk);
    #1 pop_check();
  endtask
  // n ticks ending in the transition to fin; one tickless cycle with a collision at tick 20 must change nothing
  task automatic run_ticks(input int n, input logic [2:0] st, input logic blink, input snap_t fin, input string tag);
    for (int i = 1; i <= n; i++) begin
      step(0, 1, 0, 0, tag, (i == n) ? fin : mk(st, lives, level, 0, blink & i[3]));
      if (i == 20 && n > 20) step(0, 0, 1, 0, "hold", mk(st, lives, level, 0, blink & i[3]));
    end
  endtask
  initial begin
    lives = 2'd3; level = 4'd0;
    repeat (2) @(posedge i_Clk);
    #1 exp_q.push_back(mk(S_IDLE, 3, 0, 0, 0)); tag_q.push_back("reset");
    pop_check();
    i_Rst_N = 1'b1;
    step(0, 0, 0, 0, "idle", mk(S_IDLE, 3, 0, 0, 0));
    step(1, 0, 0, 0, "start", mk(S_RUN, 3, 0, 1, 0));
    step(0, 0, 0, 0, "fr_once", mk(S_RUN, 3, 0, 0, 0));
    lives = 2'd2;
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, "col_held", mk(S_DIE, lives, level, 0, 0));
    run_ticks(60, S_DIE, 1, mk(S_RUN, lives, level, 1, 0), "die1");
    step(0, 0, 0, 0, "respawn", mk(S_RUN, lives, level, 0, 0));
    for (int k = 0; k < 2; k++) begin
      lives = lives - 2'd1;
      step(0, 0, 1, 0, "col", mk(S_DIE, lives, level, 0, 0));
      run_ticks(60, S_DIE, 1, (lives == 0) ? mk(S_OVER, 0, level, 0, 1) : mk(S_RUN, lives, level, 1, 0), "die");
      if (lives != 0) step(0, 0, 0, 0, "respawn", mk(S_RUN, lives, level, 0, 0));
    end
    step(1, 0, 0, 0, "over_hold", mk(S_OVER, 0, 0, 0, 1));
    step(0, 0, 0, 0, "over_rel", mk(S_IDLE, 0, 0, 0, 0));
    lives = 2'd3;
    step(1, 0, 0, 0, "restart", mk(S_RUN, 3, 0, 1, 0));
    lives = 2'd2;
    step(0, 0, 1, 1, "col_lvl", mk(S_DIE, 2, 0, 0, 0));
    run_ticks(60, S_DIE, 1, mk(S_RUN, 2, 0, 1, 0), "die4");
    for (int k = 1; k <= 16; k++) begin
      level = (k > 15) ? 4'd15 : 4'(k);
      step(0, 0, 0, 1, "lvl_up", mk(S_PAUSE, lives, level, 0, 0));
      run_ticks(30, S_PAUSE, 0, mk(S_RUN, lives, level, 1, 0), "pause");
    end
    step(0, 0, 0, 0, "lvl_sat", mk(S_RUN, 2, 15, 0, 0));
    lives = 2'd1;
    step(1, 0, 1, 0, "col6", mk(S_DIE, 1, 15, 0, 0));
    for (int i = 1; i <= 20; i++) step(1, 1, 0, 0, "die6", mk(S_DIE, 1, 15, 0, i[3]));
    #2 i_Rst_N = 1'b0;
    #1 exp_q.push_back(mk(S_IDLE, 3, 0, 0, 0)); tag_q.push_back("async_rst");
    pop_check();
    @(posedge i_Clk);
    #1 i_Rst_N = 1'b1;
`ifdef START_EDGE_EN
    step(1, 0, 0, 0, "held_start", mk(S_IDLE, 3, 0, 0, 0));
    step(0, 0, 0, 0, "rel_start", mk(S_IDLE, 3, 0, 0, 0));
    step(1, 0, 0, 0, "edge_start", mk(S_RUN, 3, 0, 1, 0));
`else
    step(1, 0, 0, 0, "level_start", mk(S_RUN, 3, 0, 1, 0));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
